// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential divider.
//   div_state_e : FSM state encoding
//   cnt_width() : width of the iteration counter for a given operand width
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division step (purely combinational).
//   p_in   : partial remainder from the previous step (always < d)
//   q_msb  : quotient/dividend register MSB shifted into the remainder
//   d      : divisor
//   p_out  : next partial remainder
//   q_bit  : quotient bit produced by this step
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] p_in,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] p_out,
   output logic             q_bit
);

   // The shifted remainder needs one extra bit; after the conditional
   // subtract it is below d again, so WIDTH bits are enough to store it.
   logic [WIDTH:0] p_shift;

   always_comb begin
      p_shift = {p_in, q_msb};
      q_bit   = (p_shift >= {1'b0, d});
      if (q_bit) begin
         p_out = WIDTH'(p_shift - {1'b0, d});
      end else begin
         p_out = p_shift[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (ready only while idle)
//   dividend, divisor     : unsigned operands, sampled on the input handshake
//   out_valid / out_ready : result handshake; result held until accepted
//   quotient, remainder   : dividend / divisor, dividend % divisor
//   div_by_zero           : divisor was zero (quotient all ones, remainder = dividend)
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | WIDTH shift/subtract iterations in progress
// DONE  | result presented, waiting for out_ready
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] step_p;
   logic             step_q;
   logic             accept;

   assign accept = in_valid && (state_q == IDLE);

   div_step #(.WIDTH(WIDTH)) u_step (
      .p_in  (p_q),
      .q_msb (q_q[WIDTH-1]),
      .d     (d_q),
      .p_out (step_p),
      .q_bit (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         q_q     <= q_d;
         d_q     <= d_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (divisor == '0) ? DONE : CALC;
         CALC:    if (cnt_q == LAST) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Quotient bits shift into the dividend register from the bottom while
   // dividend bits leave from the top into the partial remainder.
   always_comb begin
      cnt_d = cnt_q;
      p_d   = p_q;
      q_d   = q_q;
      d_d   = d_q;
      dbz_d = dbz_q;
      if (accept) begin
         cnt_d = '0;
         d_d   = divisor;
         if (divisor == '0) begin
            q_d   = '1;
            p_d   = dividend;
            dbz_d = 1'b1;
         end else begin
            q_d   = dividend;
            p_d   = '0;
            dbz_d = 1'b0;
         end
      end else if (state_q == CALC) begin
         cnt_d = cnt_q + 1'b1;
         p_d   = step_p;
         q_d   = {q_q[WIDTH-2:0], step_q};
      end
   end

   always_comb begin
      in_ready    = (state_q == IDLE);
      out_valid   = (state_q == DONE);
      quotient    = q_q;
      remainder   = p_q;
      div_by_zero = dbz_q;
   end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   logic       clk;
   logic       rst_n;

   logic       in_valid, in_ready, out_valid, out_ready, div_by_zero;
   logic [7:0] dividend, divisor, quotient, remainder;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, div_by_zero4;
   logic [3:0] dividend4, divisor4, quotient4, remainder4;

   int n_checks = 0;
   int n_fail   = 0;

   seq_divider #(.WIDTH(8)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   seq_divider #(.WIDTH(4)) u_dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid4),
      .in_ready    (in_ready4),
      .dividend    (dividend4),
      .divisor     (divisor4),
      .out_valid   (out_valid4),
      .out_ready   (out_ready4),
      .quotient    (quotient4),
      .remainder   (remainder4),
      .div_by_zero (div_by_zero4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division; divide by zero gives all-ones / dividend.
   function automatic int ref_q(input int a, input int b, input int w);
      return (b == 0) ? ((1 << w) - 1) : a / b;
   endfunction

   function automatic int ref_r(input int a, input int b);
      return (b == 0) ? a : a % b;
   endfunction

   // Drives one operation on the 8-bit divider from a negedge with in_ready high.
   // stall: cycles of out_ready=0 once the result is up. pulse: inject a stray
   // in_valid (60/6) mid-calculation.
   task automatic do_op8(input int a, input int b, input int stall, input bit pulse,
                         input string tag);
      int lat;
      int eq, er;
      eq = ref_q(a, b, 8);
      er = ref_r(a, b);
      out_ready = (stall == 0);
      in_valid  = 1'b1;
      dividend  = 8'(a);
      divisor   = 8'(b);
      check({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         check({tag, "_busy_in_ready"}, in_ready, 0);
         if (pulse && lat == 3) begin
            in_valid = 1'b1;
            dividend = 8'd60;
            divisor  = 8'd6;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check({tag, "_latency"}, lat, (b == 0) ? 1 : 9);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_dbz"}, div_by_zero, (b == 0) ? 1 : 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_quotient"}, quotient, eq);
         check({tag, "_hold_remainder"}, remainder, er);
         check({tag, "_hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_out_valid_drop"}, out_valid, 0);
      check({tag, "_in_ready_back"}, in_ready, 1);
   endtask

   task automatic do_op4(input int a, input int b, input int stall);
      int lat;
      out_ready4 = (stall == 0);
      in_valid4  = 1'b1;
      dividend4  = 4'(a);
      divisor4   = 4'(b);
      check("w4_in_ready", in_ready4, 1);
      @(negedge clk);
      in_valid4 = 1'b0;
      lat = 1;
      while (!out_valid4 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("w4_latency", lat, (b == 0) ? 1 : 5);
      check("w4_quotient", quotient4, ref_q(a, b, 4));
      check("w4_remainder", remainder4, ref_r(a, b));
      check("w4_dbz", div_by_zero4, (b == 0) ? 1 : 0);
      repeat (stall) @(negedge clk);
      check("w4_hold_valid", out_valid4, 1);
      out_ready4 = 1'b1;
      @(negedge clk);
      check("w4_out_valid_drop", out_valid4, 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      dividend   = '0;
      divisor    = '0;
      out_ready  = 1'b1;
      in_valid4  = 1'b0;
      dividend4  = '0;
      divisor4   = '0;
      out_ready4 = 1'b1;
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op8(200, 7, 0, 0, "t1_200_7");
      do_op8(5, 0, 0, 0, "t2_5_0");
      do_op8(3, 10, 0, 0, "t3_3_10");
      do_op8(255, 1, 0, 0, "t3_255_1");
      do_op8(0, 9, 0, 0, "t3_0_9");
      do_op8(100, 9, 5, 1, "t4_100_9");
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("t4_no_second_result", out_valid, 0);
      end

      out_ready = 1'b1;
      in_valid  = 1'b1;
      dividend  = 8'd250;
      divisor   = 8'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5_abort_out_valid", out_valid, 0);
      check("t5_abort_in_ready", in_ready, 1);
      check("t5_abort_quotient", quotient, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         check("t5_no_result", out_valid, 0);
      end
      do_op8(17, 4, 0, 0, "t5_17_4");

      for (int n = 0; n < 60; n++) begin
         int a, b;
         a = $urandom_range(0, 255);
         b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
         do_op8(a, b, $urandom_range(0, 3), 0, "rand8");
      end

      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            do_op4(i, j, $urandom_range(0, 2));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
